// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller: drives every input vector onto a small gate, samples its output
// and scores it against EXP_TABLE. Optional macro GATE_SWEEP_STOP_ON_FAIL_EN ends on first mismatch.
module gate_sweep_ctrl #(
    parameter int unsigned            N_IN       = 2,
    parameter int unsigned            SETTLE_CYC = 2,
    parameter logic [(1<<N_IN)-1:0]   EXP_TABLE  = 4'b0110
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            gate_out,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            fail_valid
);

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [N_IN:0]   FAIL_MAX    = {1'b1, {N_IN{1'b0}}};
    localparam logic [3:0]      SETTLE_LOAD = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {StIdle, StApply, StSettle, StSample, StDone} state_e;

    state_e     state;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic       sweep_end;

    assign mismatch = (gate_out != EXP_TABLE[vec_out]);

`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    assign sweep_end = (vec_out == LAST_VEC) || mismatch;
`else
    assign sweep_end = (vec_out == LAST_VEC);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            settle_cnt     <= 4'd0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_vec <= '0;
            fail_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state      <= StApply;
                        vec_out    <= '0;
                        busy       <= 1'b1;
                        fail_count <= '0;
                        fail_valid <= 1'b0;
                        pass       <= 1'b0;
                    end
                end
                StApply: begin
                    if (SETTLE_CYC > 0) begin
                        state      <= StSettle;
                        settle_cnt <= SETTLE_LOAD;
                    end else begin
                        state <= StSample;
                    end
                end
                StSettle: begin
                    if (settle_cnt == 4'd0) begin
                        state <= StSample;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                StSample: begin
                    if (mismatch) begin
                        if (fail_count != FAIL_MAX) begin
                            fail_count <= fail_count + {{N_IN{1'b0}}, 1'b1};
                        end
                        if (!fail_valid) begin
                            first_fail_vec <= vec_out;
                            fail_valid     <= 1'b1;
                        end
                    end
                    if (sweep_end) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // include the mismatch being scored on this same edge
                        pass  <= (fail_count == '0) && !mismatch;
                    end else begin
                        state   <= StApply;
                        vec_out <= vec_out + {{(N_IN-1){1'b0}}, 1'b1};
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: two instances (settle 2 and settle 0) checked every cycle against a
// timeline model derived from sweep arithmetic, plus directed literal expectations.
module tb_gate_sweep_ctrl;

    localparam int S_A = 2;
    localparam int S_B = 0;
    localparam logic [3:0] EXP = 4'b0110;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    int         mode;
    logic [1:0] vec_a, vec_b, ffv_a, ffv_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fv_a, fv_b;
    logic [2:0] fc_a, fc_b;
    logic       gate_a, gate_b;

    int checks   = 0;
    int failures = 0;

    logic [1:0] va[64];
    logic [1:0] vb[64];

    always #5 clk = ~clk;

    // mode 0 XOR, 1 AND, 2 stuck-at-1, 3 XNOR
    function automatic logic gate_fn(input int md, input logic [1:0] v);
        case (md)
            0:       return v[0] ^ v[1];
            1:       return v[0] & v[1];
            2:       return 1'b1;
            default: return ~(v[0] ^ v[1]);
        endcase
    endfunction

    assign gate_a = gate_fn(mode, vec_a);
    assign gate_b = gate_fn(mode, vec_b);

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(S_A), .EXP_TABLE(4'b0110)) dut_a (
        .clk(clk), .rst(rst), .start(start), .gate_out(gate_a), .vec_out(vec_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .fail_count(fc_a),
        .first_fail_vec(ffv_a), .fail_valid(fv_a)
    );

    gate_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(S_B), .EXP_TABLE(4'b0110)) dut_b (
        .clk(clk), .rst(rst), .start(start), .gate_out(gate_b), .vec_out(vec_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .fail_count(fc_b),
        .first_fail_vec(ffv_b), .fail_valid(fv_b)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int s_of(input int i);
        return (i == 0) ? S_A : S_B;
    endfunction

    function automatic logic [3:0] calc_mm(input int md);
        logic [3:0] e;
        logic [3:0] mm;
        e = EXP;
        for (int v = 0; v < 4; v++) mm[v] = (gate_fn(md, 2'(v)) != e[v]);
        return mm;
    endfunction

    // Sweep length: every vector costs settle+2 cycles; stop mode ends after the first bad one.
    function automatic int calc_len(input int s, input logic [3:0] mm);
        if (STOP) begin
            for (int v = 0; v < 4; v++) if (mm[v]) return (v + 1) * (s + 2);
        end
        return 4 * (s + 2);
    endfunction

    // Model: t = cycles since the accepting edge; t == len is the done cycle.
    bit         m_run[2];
    int         m_t[2];
    int         m_len[2];
    logic [3:0] m_mm[2];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_run[i] <= 1'b0;
                m_t[i]   <= 0;
            end else if (start && (!m_run[i] || m_t[i] > m_len[i])) begin
                m_run[i] <= 1'b1;
                m_t[i]   <= 0;
                m_mm[i]  <= calc_mm(mode);
                m_len[i] <= calc_len(s_of(i), calc_mm(mode));
            end else if (m_run[i] && m_t[i] <= m_len[i]) begin
                m_t[i] <= m_t[i] + 1;
            end
        end
    end

    task automatic cmp(input int i, input string nm, input logic [1:0] vec, input logic busy,
                       input logic done, input logic pass, input logic [2:0] fc,
                       input logic [1:0] ffv, input logic fv);
        bit         run;
        int         t, len, per, te, cnt, first, evec;
        logic [3:0] mm;
        run = m_run[i]; t = m_t[i]; len = m_len[i]; mm = m_mm[i];
        per = s_of(i) + 2;
        te = (t < len) ? t : len;
        cnt = 0; first = 0; evec = 0;
        if (run) begin
            evec = te / per;
            if (evec > len / per - 1) evec = len / per - 1;
            for (int v = 0; v < 4; v++) begin
                if (mm[v] && (v + 1) * per <= te) begin
                    if (cnt == 0) first = v;
                    cnt++;
                end
            end
        end
        check({nm, "_busy"}, 32'(busy), 32'(run && t < len));
        check({nm, "_done"}, 32'(done), 32'(run && t == len));
        check({nm, "_vec"}, 32'(vec), 32'(evec));
        check({nm, "_fail_count"}, 32'(fc), 32'(cnt));
        check({nm, "_fail_valid"}, 32'(fv), 32'(cnt > 0));
        check({nm, "_pass"}, 32'(pass), 32'(run && t >= len && cnt == 0));
        if (cnt > 0) check({nm, "_first_fail_vec"}, 32'(ffv), 32'(first));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            cmp(0, "A", vec_a, busy_a, done_a, pass_a, fc_a, ffv_a, fv_a);
            cmp(1, "B", vec_b, busy_b, done_b, pass_b, fc_b, ffv_b, fv_b);
        end
    end

    task automatic run_sweep(input int md, input bit hold, output int na, output int nb);
        bit ok;
        repeat (2) @(negedge clk);
        mode = md; start = 1'b1; na = 0; nb = 0; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            if (!hold) start = 1'b0;
            if (busy_a) begin va[na] = vec_a; na++; end
            if (busy_b) begin vb[nb] = vec_b; nb++; end
            if (done_a) begin ok = 1'b1; break; end
        end
        check("done_a_seen", 32'(ok), 32'd1);
    endtask

    int na, nb, gap;
    bit found;

    initial begin
        mode = 0; start = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vec", 32'(vec_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_fail_count", 32'(fc_a), 32'd0);
        rst = 1'b0;

        // XOR gate: clean sweep on both instances
        run_sweep(0, 1'b0, na, nb);
        check("xor_busy_len_a", 32'(na), 32'd16);
        check("xor_busy_len_b", 32'(nb), 32'd8);
        check("xor_vec_a_t3", 32'(va[3]), 32'd0);
        check("xor_vec_a_t4", 32'(va[4]), 32'd1);
        check("xor_vec_a_t15", 32'(va[15]), 32'd3);
        check("xor_vec_b_t1", 32'(vb[1]), 32'd0);
        check("xor_vec_b_t2", 32'(vb[2]), 32'd1);
        check("xor_pass_a", 32'(pass_a), 32'd1);
        check("xor_fail_count_a", 32'(fc_a), 32'd0);
        check("xor_fail_valid_a", 32'(fv_a), 32'd0);
        check("xor_vec_a_end", 32'(vec_a), 32'd3);
        check("xor_pass_b", 32'(pass_b), 32'd1);

        // AND gate: mismatches at 1,2,3
        run_sweep(1, 1'b0, na, nb);
        check("and_busy_len", 32'(na), STOP ? 32'd8 : 32'd16);
        check("and_fail_count", 32'(fc_a), STOP ? 32'd1 : 32'd3);
        check("and_first_fail", 32'(ffv_a), 32'd1);
        check("and_fail_valid", 32'(fv_a), 32'd1);
        check("and_pass", 32'(pass_a), 32'd0);

        // XNOR gate: every vector fails, count reaches its ceiling
        run_sweep(3, 1'b0, na, nb);
        check("xnor_fail_count", 32'(fc_a), STOP ? 32'd1 : 32'd4);
        check("xnor_first_fail", 32'(ffv_a), 32'd0);
        check("xnor_pass", 32'(pass_a), 32'd0);

        // Stuck-at-1: mismatches at 0 and 3
        run_sweep(2, 1'b0, na, nb);
        check("stuck_busy_len", 32'(na), STOP ? 32'd4 : 32'd16);
        check("stuck_fail_count", 32'(fc_a), STOP ? 32'd1 : 32'd2);
        check("stuck_first_fail", 32'(ffv_a), 32'd0);
        check("stuck_vec_end", 32'(vec_a), STOP ? 32'd0 : 32'd3);
        check("stuck_pass", 32'(pass_a), 32'd0);

        // start held high: restart only after done, via one idle cycle
        run_sweep(1, 1'b1, na, nb);
        @(posedge clk); #2;
        check("hold_idle_busy", 32'(busy_a), 32'd0);
        check("hold_idle_fail_count", 32'(fc_a), STOP ? 32'd1 : 32'd3);
        @(posedge clk); #2;
        check("hold_restart_busy", 32'(busy_a), 32'd1);
        check("hold_restart_fail_count", 32'(fc_a), 32'd0);
        gap = 2; found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #2;
            if (done_a) begin found = 1'b1; break; end
            gap++;
        end
        start = 1'b0;
        check("hold_second_done_seen", 32'(found), 32'd1);
        check("hold_done_gap", 32'(gap), STOP ? 32'd9 : 32'd17);
        repeat (30) @(negedge clk);

        // Asynchronous reset mid-sweep while vec_out == 2
        @(negedge clk);
        mode = 0; start = 1'b1; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            if (vec_a == 2'd2) begin found = 1'b1; break; end
        end
        check("abort_vec2_seen", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("abort_vec", 32'(vec_a), 32'd0);
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_fail_count", 32'(fc_a), 32'd0);
        check("abort_fail_valid", 32'(fv_a), 32'd0);
        check("abort_first_fail", 32'(ffv_a), 32'd0);
        check("abort_busy_b", 32'(busy_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep(0, 1'b0, na, nb);
        check("fresh_busy_len", 32'(na), 32'd16);
        check("fresh_pass", 32'(pass_a), 32'd1);

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
